// File: rtl/bounce_emulator.sv
// Contact-bounce generator: turns clean per-channel levels into bouncing levels
// using a shared Galois LFSR and a shared glitch tick.
module bounce_emulator #(
    parameter int          WIDTH         = 1,
    parameter int          BOUNCE_CYCLES = 4096,
    parameter int          GLITCH_PERIOD = 64,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] clean_signal,
    output logic [WIDTH-1:0] glitchy_signal,
    output logic [WIDTH-1:0] bouncing
);

    localparam int          CW         = $clog2(BOUNCE_CYCLES + 1);
    localparam int          TW         = (GLITCH_PERIOD > 1) ? $clog2(GLITCH_PERIOD) : 1;
    localparam logic [15:0] LFSR_INIT  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam logic [CW-1:0] CNT_LOAD  = CW'(BOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(GLITCH_PERIOD - 1);

    typedef enum logic {
        STABLE = 1'b0,
        BOUNCE = 1'b1
    } state_t;

    state_t          state_q [WIDTH];
    state_t          state_d [WIDTH];
    logic [CW-1:0]   cnt_q   [WIDTH];
    logic [CW-1:0]   cnt_d   [WIDTH];
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] glitchy_q, glitchy_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic            tick;

    // Shared randomness and glitch timing run every cycle, independent of enable/state.
    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end

    always_comb begin
        target_d  = target_q;
        glitchy_d = glitchy_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (!enable) begin
                state_d[i]   = STABLE;
                cnt_d[i]     = '0;
                target_d[i]  = clean_signal[i];
                glitchy_d[i] = clean_signal[i];
            end else if (clean_signal[i] != target_q[i]) begin
                // A new transition always wins, even on the last cycle of a window.
                state_d[i]   = BOUNCE;
                cnt_d[i]     = CNT_LOAD;
                target_d[i]  = clean_signal[i];
                glitchy_d[i] = clean_signal[i];
            end else begin
                case (state_q[i])
                    BOUNCE: begin
                        if (cnt_q[i] != '0) begin
                            cnt_d[i] = cnt_q[i] - CW'(1);
                            if (tick) begin
                                glitchy_d[i] = lfsr_q[i];
                            end
                        end else begin
                            state_d[i]   = STABLE;
                            glitchy_d[i] = target_q[i];
                        end
                    end
                    default: begin
                        glitchy_d[i] = target_q[i];
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q     <= LFSR_INIT;
            tick_cnt_q <= '0;
            target_q   <= '0;
            glitchy_q  <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                state_q[i] <= STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            lfsr_q     <= lfsr_d;
            tick_cnt_q <= tick_cnt_d;
            target_q   <= target_d;
            glitchy_q  <= glitchy_d;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
            bouncing[i] = (state_q[i] == BOUNCE);
        end
    end

    assign glitchy_signal = glitchy_q;

endmodule

// File: tb/tb_bounce_emulator.sv
// Bench for bounce_emulator: cycle scoreboard against a window-remaining model,
// a vector table for pass-through/entry cases, and window-length sequences.
module tb_bounce_emulator;

    localparam int B = 64;
    localparam int G = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] clean;
    logic [1:0] glitchy;
    logic [1:0] bouncing;
    logic       en0;
    logic       clean0;
    logic       glitchy0;
    logic       bouncing0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bounce_emulator #(
        .WIDTH(2), .BOUNCE_CYCLES(B), .GLITCH_PERIOD(G), .SEED(16'hACE1)
    ) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .clean_signal(clean),
        .glitchy_signal(glitchy), .bouncing(bouncing)
    );

    bounce_emulator #(
        .WIDTH(1), .BOUNCE_CYCLES(8), .GLITCH_PERIOD(1), .SEED(16'h0000)
    ) u_dut0 (
        .clk(clk), .reset(reset), .enable(en0), .clean_signal(clean0),
        .glitchy_signal(glitchy0), .bouncing(bouncing0)
    );

    // Reference model: m_rem counts the bouncing cycles still to come, including this one.
    logic [15:0] m_lfsr;
    int          m_tick;
    int          m_rem [2];
    logic [1:0]  m_tgt;
    logic [1:0]  m_gl;

    typedef struct {
        logic [1:0] g;
        logic [1:0] b;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic       en;
        logic [1:0] clean;
        logic [1:0] g;
        logic [1:0] b;
    } vec_t;
    vec_t vecs[8];

    function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_edge();
        exp_t e;
        logic tick_now;
        if (reset) begin
            m_lfsr = 16'hACE1;
            m_tick = 0;
            m_rem[0] = 0;
            m_rem[1] = 0;
            m_tgt = 2'b00;
            m_gl  = 2'b00;
        end else begin
            tick_now = (m_tick == G - 1);
            for (int i = 0; i < 2; i++) begin
                if (!enable) begin
                    m_rem[i] = 0;
                    m_tgt[i] = clean[i];
                    m_gl[i]  = clean[i];
                end else if (clean[i] != m_tgt[i]) begin
                    m_rem[i] = B;
                    m_tgt[i] = clean[i];
                    m_gl[i]  = clean[i];
                end else if (m_rem[i] >= 2) begin
                    m_rem[i] = m_rem[i] - 1;
                    if (tick_now) m_gl[i] = m_lfsr[i];
                end else begin
                    m_rem[i] = 0;
                    m_gl[i]  = m_tgt[i];
                end
            end
            m_tick = tick_now ? 0 : m_tick + 1;
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        end
        e.g = m_gl;
        e.b = {(m_rem[1] != 0), (m_rem[0] != 0)};
        sb.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        model_edge();
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            check("sb_glitchy", 16'(glitchy), 16'(e.g));
            check("sb_bouncing", 16'(bouncing), 16'(e.b));
        end
    endtask

    initial begin
        int cnt;
        int zeros;

        en0    = 1'b1;
        clean0 = 1'b0;
        enable = 1'b1;
        clean  = 2'b11;
        reset  = 1'b1;

        // Reset held with clean=11: outputs stay low, then both channels bounce.
        for (int n = 0; n < 3; n++) begin
            step();
            check("reset_glitchy", 16'(glitchy), 16'h0);
            check("reset_bouncing", 16'(bouncing), 16'h0);
        end
        check("seed0_load", u_dut0.lfsr_q, 16'hACE1);
        reset = 1'b0;
        step();
        check("post_reset_bouncing", 16'(bouncing), 16'h3);
        check("post_reset_glitchy", 16'(glitchy), 16'h3);
        check("seed0_step", u_dut0.lfsr_q, 16'hE270);
        for (int n = 0; n < B + 2; n++) step();
        check("post_reset_settled_b", 16'(bouncing), 16'h0);
        check("post_reset_settled_g", 16'(glitchy), 16'h3);

        // Bring both channels low without bouncing.
        enable = 1'b0;
        clean  = 2'b00;
        step();
        enable = 1'b1;
        step();
        check("quiet_low", 16'({glitchy, bouncing}), 16'h0);

        // Single rise on ch0.
        clean = 2'b01;
        step();
        check("rise_first_edge_g", 16'(glitchy[0]), 16'h1);
        check("rise_first_edge_b", 16'(bouncing), 16'h1);
        cnt = 1;
        for (int n = 0; n < 300; n++) begin
            step();
            if (glitchy[1] !== 1'b0 || bouncing[1] !== 1'b0) begin
                check("rise_ch1_untouched", 16'({glitchy[1], bouncing[1]}), 16'h0);
            end
            if (bouncing[0]) cnt++;
            else break;
        end
        check("rise_window_len", 16'(cnt), 16'(B));
        check("rise_final_level", 16'(glitchy[0]), 16'h1);

        // Retrigger: toggle again on cycle 30 of the window.
        clean = 2'b00;
        step();
        cnt = 1;
        for (int n = 0; n < 29; n++) begin
            step();
            if (bouncing[0]) cnt++;
        end
        clean = 2'b01;
        for (int n = 0; n < 300; n++) begin
            step();
            if (bouncing[0]) cnt++;
            else break;
        end
        check("retrigger_window_len", 16'(cnt), 16'(30 + B));
        check("retrigger_final_level", 16'(glitchy[0]), 16'h1);

        // Abort: enable drops on cycle 10 of a window.
        clean = 2'b00;
        step();
        for (int n = 0; n < 9; n++) step();
        check("abort_pre_bouncing", 16'(bouncing), 16'h1);
        enable = 1'b0;
        step();
        check("abort_bouncing", 16'(bouncing), 16'h0);
        check("abort_glitchy", 16'(glitchy), 16'(clean));
        for (int n = 0; n < 6; n++) begin
            clean = 2'(n + 1);
            step();
            check("abort_track", 16'({glitchy, bouncing}), 16'({clean, 2'b00}));
        end

        // Vector table: pass-through and deterministic window entry.
        vecs[0] = '{en: 1'b0, clean: 2'b01, g: 2'b01, b: 2'b00};
        vecs[1] = '{en: 1'b0, clean: 2'b10, g: 2'b10, b: 2'b00};
        vecs[2] = '{en: 1'b0, clean: 2'b11, g: 2'b11, b: 2'b00};
        vecs[3] = '{en: 1'b1, clean: 2'b11, g: 2'b11, b: 2'b00};
        vecs[4] = '{en: 1'b1, clean: 2'b10, g: 2'b10, b: 2'b01};
        vecs[5] = '{en: 1'b0, clean: 2'b10, g: 2'b10, b: 2'b00};
        vecs[6] = '{en: 1'b1, clean: 2'b00, g: 2'b00, b: 2'b10};
        vecs[7] = '{en: 1'b0, clean: 2'b01, g: 2'b01, b: 2'b00};
        enable = 1'b0;
        clean  = 2'b00;
        step();
        for (int v = 0; v < 8; v++) begin
            enable = vecs[v].en;
            clean  = vecs[v].clean;
            step();
            check($sformatf("vec%0d_glitchy", v), 16'(glitchy), 16'(vecs[v].g));
            check($sformatf("vec%0d_bouncing", v), 16'(bouncing), 16'(vecs[v].b));
        end

        // Reset in the middle of a window leaves nothing behind.
        enable = 1'b1;
        clean  = 2'b00;
        step();
        clean = 2'b11;
        for (int n = 0; n < 5; n++) step();
        reset = 1'b1;
        step();
        check("midreset_outputs", 16'({glitchy, bouncing}), 16'h0);
        clean = 2'b00;
        reset = 1'b0;
        for (int n = 0; n < 3; n++) step();
        check("midreset_quiet", 16'({glitchy, bouncing}), 16'h0);

        // SEED=0 instance: full LFSR period returns to the substitute seed, never zero.
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("seed0_reload", u_dut0.lfsr_q, 16'hACE1);
        reset = 1'b0;
        zeros = 0;
        for (int n = 0; n < 65535; n++) begin
            @(posedge clk);
            #1;
            if (u_dut0.lfsr_q == 16'h0000) zeros++;
        end
        check("seed0_no_zero", 16'(zeros), 16'h0);
        check("seed0_period", u_dut0.lfsr_q, 16'hACE1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
